// File: rtl/uart_status_responder_if.sv
// Request, register read-back and uart_tx byte handshake
// between the command decoder, the register file and uart_tx.
interface uart_status_responder_if;
  logic        req;
  logic [7:0]  req_func;
  logic [7:0]  req_ch;
  logic        req_drop;
  logic        resp_busy;
  logic        resp_done;

  logic [7:0]  rd_ch;
  logic [7:0]  rd_ctrl_sta;
  logic [7:0]  rd_duty_num;
  logic [15:0] rd_pulse_dessert;
  logic [7:0]  rd_pulse_num;
  logic [31:0] rd_PAT;
  logic        rd_busy;
  logic        rd_valid;

  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_busy;

  modport slave (
    input  req, req_func, req_ch,
    output req_drop, resp_busy, resp_done,
    output rd_ch,
    input  rd_ctrl_sta, rd_duty_num,
    input  rd_pulse_dessert, rd_pulse_num,
    input  rd_PAT, rd_busy, rd_valid,
    output tx_en, tx_data,
    input  tx_busy
  );

  modport master (
    output req, req_func, req_ch,
    input  req_drop, resp_busy, resp_done,
    input  rd_ch,
    output rd_ctrl_sta, rd_duty_num,
    output rd_pulse_dessert, rd_pulse_num,
    output rd_PAT, rd_busy, rd_valid,
    input  tx_en, tx_data,
    output tx_busy
  );
endinterface

// File: rtl/uart_status_responder.sv
// Builds a 14-byte status frame for one channel
// and streams it byte-by-byte into uart_tx.
module uart_status_responder #(
  parameter int         _NUM_CHANNELS = 3,
  parameter int         _PAT_WIDTH    = 32,
  parameter logic [7:0] _HDR0         = 8'h55,
  parameter logic [7:0] _HDR1         = 8'hAA
) (
  input logic clk_50M,
  input logic rst,
  uart_status_responder_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SEND,
    WAIT_HI,
    WAIT_LO,
    FINISH
  } state_t;

  state_t     state;
  logic [3:0] idx;
  logic [7:0] chk;
  logic [1:0] tmo;
  logic [7:0] func_r;
  logic [7:0] ch_r;
  // pay[0] is the frame func byte, pay[1..10] are d1..d10
  logic [7:0] pay [0:10];
  logic [7:0] cur;
  logic       bad;
  logic [_PAT_WIDTH-1:0] pat;

  assign pat = bus.rd_PAT;

  assign bad = (ch_r >= 8'(_NUM_CHANNELS)) ||
               !(func_r == 8'h01 || func_r == 8'h02);

  assign bus.req_drop = bus.req & bus.resp_busy;

  always_comb begin
    cur = 8'h00;
    case (idx)
      4'd0:    cur = _HDR0;
      4'd1:    cur = _HDR1;
      4'd13:   cur = chk;
      default: cur = pay[idx - 4'd2];
    endcase
  end

  always_ff @(posedge clk_50M) begin
    if (rst) begin
      state         <= IDLE;
      idx           <= 4'd0;
      chk           <= 8'h00;
      tmo           <= 2'd0;
      func_r        <= 8'h00;
      ch_r          <= 8'h00;
      bus.rd_ch     <= 8'h00;
      bus.tx_en     <= 1'b0;
      bus.tx_data   <= 8'h00;
      bus.resp_busy <= 1'b0;
      bus.resp_done <= 1'b0;
      for (int i = 0; i < 11; i++)
        pay[i] <= 8'h00;
    end else begin
      bus.tx_en     <= 1'b0;
      bus.resp_done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.req) begin
            func_r        <= bus.req_func;
            ch_r          <= bus.req_ch;
            bus.rd_ch     <= bus.req_ch;
            bus.resp_busy <= 1'b1;
            idx           <= 4'd0;
            chk           <= 8'h00;
            state         <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          for (int i = 0; i < 11; i++)
            pay[i] <= 8'h00;
          pay[1] <= ch_r;
          unique case (1'b1)
            bad: begin
              pay[0] <= func_r | 8'h80;
              pay[2] <= 8'hEE;
            end
            !bad && func_r == 8'h01: begin
              pay[0]  <= func_r;
              pay[2]  <= bus.rd_ctrl_sta;
              pay[3]  <= bus.rd_duty_num;
              pay[4]  <= bus.rd_pulse_dessert[15:8];
              pay[5]  <= bus.rd_pulse_dessert[7:0];
              pay[6]  <= bus.rd_pulse_num;
              pay[7]  <= pat[31:24];
              pay[8]  <= pat[23:16];
              pay[9]  <= pat[15:8];
              pay[10] <= pat[7:0];
            end
            !bad && func_r == 8'h02: begin
              pay[0] <= func_r;
              pay[2] <= bus.rd_ctrl_sta;
              pay[3] <= {6'b0, bus.rd_busy,
                         bus.rd_valid};
            end
          endcase
          state <= SEND;
        end
        SEND: begin
          if (!bus.tx_busy) begin
            bus.tx_data <= cur;
            bus.tx_en   <= 1'b1;
            // running sum covers func..d10 only
            if (idx >= 4'd2 && idx <= 4'd12)
              chk <= chk + cur;
            tmo   <= 2'd0;
            state <= WAIT_HI;
          end
        end
        WAIT_HI: begin
          if (bus.tx_busy) begin
            state <= WAIT_LO;
          end else if (tmo == 2'd3) begin
            if (idx < 4'd13) begin
              idx   <= idx + 4'd1;
              state <= SEND;
            end else begin
              state <= FINISH;
            end
          end else begin
            tmo <= tmo + 2'd1;
          end
        end
        WAIT_LO: begin
          if (!bus.tx_busy) begin
            if (idx < 4'd13) begin
              idx   <= idx + 4'd1;
              state <= SEND;
            end else begin
              state <= FINISH;
            end
          end
        end
        FINISH: begin
          bus.resp_done <= 1'b1;
          bus.resp_busy <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_status_responder.sv
// Scoreboard bench: expected frame bytes are queued at request
// time and popped by a monitor on every tx_en pulse.
module tb_uart_status_responder;

  logic clk;
  logic rst;

  uart_status_responder_if bus ();

  uart_status_responder dut (
    .clk_50M (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int en_cnt = 0;
  int done_cnt = 0;
  int req_cyc = 0;
  int first_en_cyc = -1;
  bit first_pending = 0;
  bit gap_chk = 0;
  int prev_en = -1;

  logic [7:0] sb [$];

  logic [7:0]  t_ctrl [0:2];
  logic [7:0]  t_duty [0:2];
  logic [15:0] t_des [0:2];
  logic [7:0]  t_num [0:2];
  logic [31:0] t_pat [0:2];
  logic        t_busy [0:2];
  logic        t_valid [0:2];

  logic       model_busy;
  logic [3:0] model_cnt;
  logic       hold_busy;
  logic       no_busy;

  assign bus.tx_busy = model_busy | hold_busy;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // register file: 1-cycle read latency
  always @(posedge clk) begin
    if (bus.rd_ch < 8'd3) begin
      bus.rd_ctrl_sta      <= t_ctrl[bus.rd_ch[1:0]];
      bus.rd_duty_num      <= t_duty[bus.rd_ch[1:0]];
      bus.rd_pulse_dessert <= t_des[bus.rd_ch[1:0]];
      bus.rd_pulse_num     <= t_num[bus.rd_ch[1:0]];
      bus.rd_PAT           <= t_pat[bus.rd_ch[1:0]];
      bus.rd_busy          <= t_busy[bus.rd_ch[1:0]];
      bus.rd_valid         <= t_valid[bus.rd_ch[1:0]];
    end else begin
      bus.rd_ctrl_sta      <= 8'h5A;
      bus.rd_duty_num      <= 8'h5A;
      bus.rd_pulse_dessert <= 16'h5A5A;
      bus.rd_pulse_num     <= 8'h5A;
      bus.rd_PAT           <= 32'h5A5A5A5A;
      bus.rd_busy          <= 1'b1;
      bus.rd_valid         <= 1'b1;
    end
  end

  // uart_tx: busy for 10 cycles after each tx_en
  always @(posedge clk) begin
    if (rst) begin
      model_busy <= 1'b0;
      model_cnt  <= 4'd0;
    end else if (bus.tx_en && !no_busy) begin
      model_busy <= 1'b1;
      model_cnt  <= 4'd9;
    end else if (model_cnt != 4'd0) begin
      model_cnt <= model_cnt - 4'd1;
    end else begin
      model_busy <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.tx_en) begin
        en_cnt++;
        if (first_pending) begin
          first_en_cyc  = cyc;
          first_pending = 0;
        end
        if (gap_chk && prev_en >= 0)
          check("timeout_gap", cyc - prev_en, 5);
        prev_en = cyc;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_byte: got %0h, expected none",
                   bus.tx_data);
        end else begin
          check("frame_byte", bus.tx_data, sb.pop_front());
        end
      end
      if (bus.resp_done) done_cnt++;
    end
  end

  task automatic push_frame(input logic [111:0] f);
    for (int i = 13; i >= 0; i--)
      sb.push_back(f[i*8 +: 8]);
  endtask

  task automatic send_req(input logic [7:0] func,
                          input logic [7:0] ch);
    @(posedge clk);
    #1;
    bus.req      = 1'b1;
    bus.req_func = func;
    bus.req_ch   = ch;
    first_pending = 1;
    @(posedge clk);
    #1;
    bus.req = 1'b0;
    @(negedge clk);
    req_cyc = cyc;
  endtask

  task automatic wait_done(input string name);
    int base;
    int n;
    base = done_cnt;
    n = 0;
    while (done_cnt == base && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    check({name, "_done"}, done_cnt - base, 1);
    check({name, "_sb_empty"}, sb.size(), 0);
    check({name, "_busy_clr"}, bus.resp_busy, 0);
  endtask

  task automatic wait_en(input int target);
    int n;
    n = 0;
    while (en_cnt < target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("en_wait", (en_cnt >= target), 1);
  endtask

  initial begin
    int base;
    t_ctrl[0] = 8'h01; t_duty[0] = 8'h77;
    t_des[0] = 16'h8899; t_num[0] = 8'h66;
    t_pat[0] = 32'hCAFEF00D;
    t_busy[0] = 1'b1; t_valid[0] = 1'b0;
    t_ctrl[1] = 8'h01; t_duty[1] = 8'h10;
    t_des[1] = 16'h0203; t_num[1] = 8'h04;
    t_pat[1] = 32'hDEADBEEF;
    t_busy[1] = 1'b0; t_valid[1] = 1'b1;
    t_ctrl[2] = 8'h80; t_duty[2] = 8'h33;
    t_des[2] = 16'h1234; t_num[2] = 8'h05;
    t_pat[2] = 32'h01020304;
    t_busy[2] = 1'b1; t_valid[2] = 1'b1;

    rst = 1'b1;
    bus.req = 1'b0;
    bus.req_func = 8'h00;
    bus.req_ch = 8'h00;
    hold_busy = 1'b0;
    no_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_en", bus.tx_en, 0);
    check("rst_tx_data", bus.tx_data, 0);
    check("rst_resp_busy", bus.resp_busy, 0);
    check("rst_resp_done", bus.resp_done, 0);
    check("rst_req_drop", bus.req_drop, 0);
    check("rst_rd_ch", bus.rd_ch, 0);
    #1 rst = 1'b0;

    // hs params, ch1: checksum 0x54
    push_frame(112'h55AA_0101_0110_0203_04DE_ADBE_EF54);
    send_req(8'h01, 8'h01);
    check("rd_ch", bus.rd_ch, 8'h01);
    check("resp_busy_set", bus.resp_busy, 1);
    wait_done("hs");
    check("req_to_tx_en", first_en_cyc - req_cyc, 3);

    // ls status, ch0
    push_frame(112'h55AA_0200_0102_0000_0000_0000_0005);
    send_req(8'h02, 8'h00);
    wait_done("ls");

    // invalid channel
    push_frame(112'h55AA_8103_EE00_0000_0000_0000_0072);
    send_req(8'h01, 8'h03);
    wait_done("badch");

    // back-pressure then a dropped overlapping request
    hold_busy = 1'b1;
    base = en_cnt;
    push_frame(112'h55AA_0102_8033_1234_0501_0203_040B);
    send_req(8'h01, 8'h02);
    repeat (50) @(negedge clk);
    check("hold_no_tx_en", en_cnt - base, 0);
    #1 hold_busy = 1'b0;
    wait_en(base + 3);
    @(posedge clk);
    #1;
    bus.req      = 1'b1;
    bus.req_func = 8'h02;
    bus.req_ch   = 8'h00;
    @(negedge clk);
    check("req_drop", bus.req_drop, 1);
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    check("req_drop_clr", bus.req_drop, 0);
    wait_done("bp");

    // reset after the fifth byte
    base = en_cnt;
    push_frame(112'h55AA_0101_0110_0203_04DE_ADBE_EF54);
    send_req(8'h01, 8'h01);
    wait_en(base + 5);
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_tx_en", bus.tx_en, 0);
    check("midrst_resp_busy", bus.resp_busy, 0);
    repeat (15) @(negedge clk);
    check("midrst_idle_en", en_cnt - base, 5);
    push_frame(112'h55AA_0101_0110_0203_04DE_ADBE_EF54);
    send_req(8'h01, 8'h01);
    wait_done("after_rst");

    // uart_tx never raises busy
    no_busy = 1'b1;
    base = en_cnt;
    prev_en = -1;
    gap_chk = 1;
    push_frame(112'h55AA_0200_0102_0000_0000_0000_0005);
    send_req(8'h02, 8'h00);
    wait_done("timeout");
    gap_chk = 0;
    check("timeout_bytes", en_cnt - base, 14);
    no_busy = 1'b0;

    repeat (5) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
